// File: rtl/component_bitstream_packer.sv
// Packs variable-length MSB-first codewords into 32-bit big-endian words for slice memory,
// padding to a byte boundary on flush and tracking the number of bytes emitted.
module component_bitstream_packer #(
    parameter int MAX_BITS = 32,
    parameter int ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              component_reset_n,
    input  logic              sb_enable,
    input  logic [63:0]       sb_val,
    input  logic [63:0]       sb_size_of_bit,
    input  logic              sb_flush,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [3:0]        out_byte_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       byte_count,
    output logic              flush_done,
    output logic              size_error
);

    typedef enum logic {RUN = 1'b0, FLUSH_TAIL = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [63:0]       acc_r, acc_s, acc_a_s, val_s;
    logic [6:0]        fill_r, fill_s, fill_a_s, n_s, p_s;
    logic              over_s, emit_s, done_s, err_s;
    logic [3:0]        be_s;
    logic [31:0]       data_s;
    logic [ADDR_W-1:0] next_addr_r;
    logic              out_valid_r, flush_done_r, size_error_r;
    logic [31:0]       out_data_r, byte_count_r;
    logic [3:0]        out_byte_en_r;
    logic [ADDR_W-1:0] out_addr_r;

    function automatic logic [3:0] byte_mask(input logic [6:0] bits);
        logic [3:0] m;
        case (bits[5:3])
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1100;
            3'd3:    m = 4'b1110;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Append the current beat below the valid bits and compute the byte-padded length.
    always_comb begin
        over_s   = (sb_size_of_bit > 64'(MAX_BITS));
        n_s      = over_s ? 7'(MAX_BITS) : sb_size_of_bit[6:0];
        val_s    = sb_val & ((64'd1 << n_s) - 64'd1);
        if (sb_enable && (state_r == RUN)) begin
            acc_a_s  = acc_r | (val_s << (7'd64 - fill_r - n_s));
            fill_a_s = fill_r + n_s;
        end else begin
            acc_a_s  = acc_r;
            fill_a_s = fill_r;
        end
        p_s = (fill_a_s + 7'd7) & 7'b1111000;
    end

    // Next-state, emission and error decisions.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        fill_s  = fill_r;
        emit_s  = 1'b0;
        be_s    = 4'h0;
        data_s  = acc_a_s[63:32];
        done_s  = 1'b0;
        err_s   = size_error_r;
        case (state_r)
            RUN: begin
                if (sb_enable && over_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = size_error_r;
                end
                if (sb_flush) begin
                    if (p_s > 7'd32) begin
                        emit_s  = 1'b1;
                        be_s    = 4'hF;
                        acc_s   = acc_a_s << 32;
                        fill_s  = p_s - 7'd32;
                        state_s = FLUSH_TAIL;
                    end else begin
                        emit_s = (p_s != 7'd0);
                        be_s   = byte_mask(p_s);
                        done_s = 1'b1;
                        acc_s  = 64'd0;
                        fill_s = 7'd0;
                    end
                end else if (fill_a_s >= 7'd32) begin
                    emit_s = 1'b1;
                    be_s   = 4'hF;
                    acc_s  = acc_a_s << 32;
                    fill_s = fill_a_s - 7'd32;
                end else begin
                    acc_s  = acc_a_s;
                    fill_s = fill_a_s;
                end
            end
            FLUSH_TAIL: begin
                // fill holds the byte-aligned remainder; padding bits are already zero
                emit_s  = 1'b1;
                be_s    = byte_mask(fill_r);
                done_s  = 1'b1;
                acc_s   = 64'd0;
                fill_s  = 7'd0;
                state_s = RUN;
                if (sb_enable) begin
                    err_s = 1'b1;
                end else begin
                    err_s = size_error_r;
                end
            end
            default: begin
                state_s = RUN;
                acc_s   = 64'd0;
                fill_s  = 7'd0;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clock or negedge component_reset_n) begin
        if (!component_reset_n) begin
            state_r       <= RUN;
            acc_r         <= 64'd0;
            fill_r        <= 7'd0;
            next_addr_r   <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= 32'd0;
            out_byte_en_r <= 4'h0;
            out_addr_r    <= '0;
            byte_count_r  <= 32'd0;
            flush_done_r  <= 1'b0;
            size_error_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            acc_r         <= acc_s;
            fill_r        <= fill_s;
            out_valid_r   <= emit_s;
            flush_done_r  <= done_s;
            size_error_r  <= err_s;
            out_byte_en_r <= emit_s ? be_s : 4'h0;
            if (emit_s) begin
                out_data_r   <= data_s;
                out_addr_r   <= next_addr_r;
                next_addr_r  <= next_addr_r + 1'b1;
                byte_count_r <= byte_count_r + {29'd0, popcount4(be_s)};
            end else begin
                out_data_r   <= out_data_r;
                out_addr_r   <= out_addr_r;
                next_addr_r  <= next_addr_r;
                byte_count_r <= byte_count_r;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_byte_en = out_byte_en_r;
    assign out_addr    = out_addr_r;
    assign byte_count  = byte_count_r;
    assign flush_done  = flush_done_r;
    assign size_error  = size_error_r;

endmodule

// File: tb/tb_component_bitstream_packer.sv
// Directed bench for component_bitstream_packer: hand-computed words, byte enables,
// addresses, byte counts, flush pulses and error flag.
module tb_component_bitstream_packer;

    logic        clock = 1'b0;
    logic        component_reset_n = 1'b0;
    logic        sb_enable = 1'b0;
    logic [63:0] sb_val = 64'd0;
    logic [63:0] sb_size_of_bit = 64'd0;
    logic        sb_flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_byte_en;
    logic [15:0] out_addr;
    logic [31:0] byte_count;
    logic        flush_done;
    logic        size_error;

    int total = 0;
    int bad = 0;

    component_bitstream_packer #(.MAX_BITS(32), .ADDR_W(16)) dut (
        .clock(clock), .component_reset_n(component_reset_n),
        .sb_enable(sb_enable), .sb_val(sb_val), .sb_size_of_bit(sb_size_of_bit),
        .sb_flush(sb_flush), .out_valid(out_valid), .out_data(out_data),
        .out_byte_en(out_byte_en), .out_addr(out_addr), .byte_count(byte_count),
        .flush_done(flush_done), .size_error(size_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the capturing edge.
    task automatic step(input logic en, input logic [63:0] v, input logic [63:0] s, input logic f);
        sb_enable = en; sb_val = v; sb_size_of_bit = s; sb_flush = f;
        @(posedge clock); #1;
        sb_enable = 1'b0; sb_val = 64'd0; sb_size_of_bit = 64'd0; sb_flush = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
        chk({tag, "_be"}, {60'd0, out_byte_en}, 64'd0);
        chk({tag, "_addr"}, {48'd0, out_addr}, 64'd0);
        chk({tag, "_bytes"}, {32'd0, byte_count}, 64'd0);
        chk({tag, "_done"}, {63'd0, flush_done}, 64'd0);
        chk({tag, "_err"}, {63'd0, size_error}, 64'd0);
    endtask

    task automatic do_reset();
        component_reset_n = 1'b0;
        #2;
        check_zero("rst");
        @(negedge clock);
        component_reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #3;
        do_reset();

        // 32 single one-bits -> one all-ones word
        for (int i = 0; i < 31; i++) step(1'b1, 64'd1, 64'd1, 1'b0);
        chk("ones_early", {63'd0, out_valid}, 64'd0);
        step(1'b1, 64'd1, 64'd1, 1'b0);
        chk("ones_valid", {63'd0, out_valid}, 64'd1);
        chk("ones_data", {32'd0, out_data}, 64'hFFFF_FFFF);
        chk("ones_addr", {48'd0, out_addr}, 64'd0);
        chk("ones_be", {60'd0, out_byte_en}, 64'hF);
        step(1'b0, 64'd0, 64'd0, 1'b0);
        chk("ones_idle", {63'd0, out_valid}, 64'd0);

        // 5 + 27 bits with flush reaching exactly one word
        do_reset();
        step(1'b1, 64'h15, 64'd5, 1'b0);
        step(1'b1, 64'h0, 64'd27, 1'b1);
        chk("w32_valid", {63'd0, out_valid}, 64'd1);
        chk("w32_data", {32'd0, out_data}, 64'hA800_0000);
        chk("w32_be", {60'd0, out_byte_en}, 64'hF);
        chk("w32_done", {63'd0, flush_done}, 64'd1);
        chk("w32_bytes", {32'd0, byte_count}, 64'd4);

        // 3 bits with same-cycle flush -> single byte
        do_reset();
        step(1'b1, 64'h5, 64'd3, 1'b1);
        chk("b1_valid", {63'd0, out_valid}, 64'd1);
        chk("b1_data", {32'd0, out_data}, 64'hA000_0000);
        chk("b1_be", {60'd0, out_byte_en}, 64'b1000);
        chk("b1_done", {63'd0, flush_done}, 64'd1);
        chk("b1_bytes", {32'd0, byte_count}, 64'd1);
        chk("b1_addr", {48'd0, out_addr}, 64'd0);

        // fill=1, then 32 ones with flush: p=40 -> full word then 1-byte tail
        step(1'b1, 64'h0, 64'd1, 1'b0);
        step(1'b1, 64'hFFFF_FFFF, 64'd32, 1'b1);
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_data", {32'd0, out_data}, 64'h7FFF_FFFF);
        chk("t1_be", {60'd0, out_byte_en}, 64'hF);
        chk("t1_done", {63'd0, flush_done}, 64'd0);
        chk("t1_addr", {48'd0, out_addr}, 64'd1);
        step(1'b1, 64'hF, 64'd4, 1'b0);
        chk("t2_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_data", {32'd0, out_data}, 64'h8000_0000);
        chk("t2_be", {60'd0, out_byte_en}, 64'b1000);
        chk("t2_done", {63'd0, flush_done}, 64'd1);
        chk("t2_addr", {48'd0, out_addr}, 64'd2);
        chk("t2_bytes", {32'd0, byte_count}, 64'd6);
        chk("t2_err", {63'd0, size_error}, 64'd1);

        // fill=31, then 32 ones with flush: p=64 -> two full words
        step(1'b1, 64'h0, 64'd31, 1'b0);
        step(1'b1, 64'hFFFF_FFFF, 64'd32, 1'b1);
        chk("f1_data", {32'd0, out_data}, 64'h0000_0001);
        chk("f1_addr", {48'd0, out_addr}, 64'd3);
        step(1'b0, 64'd0, 64'd0, 1'b0);
        chk("f2_data", {32'd0, out_data}, 64'hFFFF_FFFE);
        chk("f2_be", {60'd0, out_byte_en}, 64'hF);
        chk("f2_done", {63'd0, flush_done}, 64'd1);
        chk("f2_bytes", {32'd0, byte_count}, 64'd14);

        // size 0 is a no-op; empty flush pulses done without a word
        do_reset();
        step(1'b1, 64'hFFFF, 64'd0, 1'b0);
        chk("z_err", {63'd0, size_error}, 64'd0);
        step(1'b0, 64'd0, 64'd0, 1'b1);
        chk("z_done", {63'd0, flush_done}, 64'd1);
        chk("z_valid", {63'd0, out_valid}, 64'd0);

        // oversize beat: error, exactly 32 bits appended
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd40, 1'b0);
        chk("os_err", {63'd0, size_error}, 64'd1);
        chk("os_valid", {63'd0, out_valid}, 64'd1);
        chk("os_data", {32'd0, out_data}, 64'hFFFF_FFFF);
        step(1'b0, 64'd0, 64'd0, 1'b1);
        chk("os_empty", {63'd0, out_valid}, 64'd0);
        chk("os_sticky", {63'd0, size_error}, 64'd1);

        // reset with fill=20 discards the partial word
        step(1'b1, 64'hFFFFF, 64'd20, 1'b0);
        component_reset_n = 1'b0;
        #2;
        check_zero("mid");
        @(negedge clock);
        component_reset_n = 1'b1;
        @(posedge clock); #1;
        step(1'b0, 64'd0, 64'd0, 1'b1);
        chk("mid_done", {63'd0, flush_done}, 64'd1);
        chk("mid_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_bytes", {32'd0, byte_count}, 64'd0);

        // address wrap after 2^16 words
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 64'h1234_5678, 64'd32, 1'b0);
            if (i == 65535) chk("wrap_last", {48'd0, out_addr}, 64'hFFFF);
        end
        step(1'b1, 64'hCAFE_F00D, 64'd32, 1'b0);
        chk("wrap_addr", {48'd0, out_addr}, 64'd0);
        chk("wrap_data", {32'd0, out_data}, 64'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
